// File: rtl/pulse_envelope_gen.sv
// Trapezoidal pulse envelope engine: rise / hold / fall per command, one DAC sample per clk.
// Latency: first rise sample one cycle after the accepting edge; one pending slot, ready drops while it is full.
module pulse_envelope_gen #(
    parameter int AMP_WIDTH  = 12,
    parameter int LEN_WIDTH  = 12,
    parameter int STEP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          cmd_data,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    output logic [AMP_WIDTH-1:0] sample_out,
    output logic                 busy,
    output logic                 pulse_done
);

    localparam int SW = AMP_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} state_t;

    state_t                 state, state_nxt;
    logic [AMP_WIDTH-1:0]   acc, acc_nxt;
    logic [LEN_WIDTH-1:0]   hcnt, hcnt_nxt;
    logic [AMP_WIDTH-1:0]   a_amp, a_amp_nxt;
    logic [LEN_WIDTH-1:0]   a_len, a_len_nxt;
    logic [STEP_WIDTH-1:0]  a_step, a_step_nxt;
    logic                   pend_v, pend_v_nxt;
    logic [31:0]            pend, pend_nxt;
    logic                   done_nxt;

    logic                   accept, launch;
    logic [31:0]            l_cmd;
    logic [AMP_WIDTH-1:0]   l_amp, l_first;
    logic [LEN_WIDTH-1:0]   l_len;
    logic [STEP_WIDTH-1:0]  l_step;
    logic [SW-1:0]          a_step_w, rise_sum;

    assign cmd_ready  = !pend_v && !rst;
    assign accept     = cmd_valid && cmd_ready;
    assign launch     = (state == IDLE) && (pend_v || accept);
    assign sample_out = acc;
    assign busy       = (state != IDLE);

    // The pending slot has priority; a direct launch only happens when it is empty.
    assign l_cmd   = pend_v ? pend : cmd_data;
    assign l_amp   = l_cmd[31 -: AMP_WIDTH];
    assign l_len   = l_cmd[STEP_WIDTH +: LEN_WIDTH];
    assign l_step  = l_cmd[STEP_WIDTH-1:0];
    assign l_first = (l_step == '0 || SW'(l_step) >= {1'b0, l_amp}) ? l_amp : AMP_WIDTH'(l_step);

    assign a_step_w = SW'(a_step);
    assign rise_sum = {1'b0, acc} + a_step_w;

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        hcnt_nxt   = hcnt;
        a_amp_nxt  = a_amp;
        a_len_nxt  = a_len;
        a_step_nxt = a_step;
        pend_v_nxt = pend_v;
        pend_nxt   = pend;
        done_nxt   = 1'b0;

        if (launch && pend_v)
            pend_v_nxt = 1'b0;
        if (accept && state != IDLE) begin
            pend_v_nxt = 1'b1;
            pend_nxt   = cmd_data;
        end

        case (state)
            IDLE: begin
                if (launch) begin
                    a_amp_nxt  = l_amp;
                    a_len_nxt  = l_len;
                    a_step_nxt = l_step;
                    acc_nxt    = l_first;
                    if (l_first != l_amp) begin
                        state_nxt = RISE;
                    end else if (l_len == '0) begin
                        state_nxt = FALL;
                    end else begin
                        state_nxt = HOLD;
                        hcnt_nxt  = l_len;
                    end
                end
            end
            RISE: begin
                if (rise_sum >= {1'b0, a_amp}) begin
                    acc_nxt = a_amp;
                    if (a_len == '0) begin
                        state_nxt = FALL;
                    end else begin
                        state_nxt = HOLD;
                        hcnt_nxt  = a_len;
                    end
                end else begin
                    acc_nxt = rise_sum[AMP_WIDTH-1:0];
                end
            end
            HOLD: begin
                // The first cycle of FALL still shows amp, so leave HOLD one count early.
                hcnt_nxt = hcnt - 1'b1;
                if (hcnt <= LEN_WIDTH'(1))
                    state_nxt = FALL;
            end
            FALL: begin
                if (a_step != '0 && {1'b0, acc} > a_step_w) begin
                    acc_nxt = acc - AMP_WIDTH'(a_step);
                end else begin
                    acc_nxt   = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            hcnt       <= '0;
            a_amp      <= '0;
            a_len      <= '0;
            a_step     <= '0;
            pend_v     <= 1'b0;
            pend       <= '0;
            pulse_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            hcnt       <= hcnt_nxt;
            a_amp      <= a_amp_nxt;
            a_len      <= a_len_nxt;
            a_step     <= a_step_nxt;
            pend_v     <= pend_v_nxt;
            pend       <= pend_nxt;
            pulse_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_envelope_gen.sv
// Directed bench for pulse_envelope_gen: hand-computed sample/busy/done/ready sequences.
module tb_pulse_envelope_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] sample_out;
    logic        busy;
    logic        pulse_done;

    int vecs = 0;
    int miss = 0;
    int exp_s [64];

    pulse_envelope_gen #(.AMP_WIDTH(12), .LEN_WIDTH(12), .STEP_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .sample_out (sample_out),
        .busy       (busy),
        .pulse_done (pulse_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_cmd(input int amp, input int len, input int step);
        return {amp[11:0], len[11:0], step[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        if (obs !== expv) begin
            miss++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Checks n consecutive cycles against exp_s; busy until the last, done on the last.
    task automatic play(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s sample[%0d]", tag, i), 32'(sample_out), 32'(exp_s[i]));
            chk($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'(i < n - 1));
            chk($sformatf("%s done[%0d]", tag, i), 32'(pulse_done), 32'(i == n - 1));
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [31:0] c);
        cmd_data  = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 32'hDEAD_BEEF;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bs [9];
        int bb [9];
        int bd [9];
        int br [9];
        int k;
        int max_s;
        int any_done;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        repeat (2) @(negedge clk);
        chk("reset sample", 32'(sample_out), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(pulse_done), 0);
        chk("reset ready", 32'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        chk("ready after reset", 32'(cmd_ready), 1);
        @(negedge clk);

        // Basic trapezoid
        exp_s[0:8] = '{40, 80, 100, 100, 100, 100, 60, 20, 0};
        send(mk_cmd(100, 3, 40));
        play("basic", 9);
        chk("basic idle after", 32'(pulse_done), 0);

        // Step 0 / len 0, then a direct launch on the done cycle
        send(mk_cmd(500, 0, 0));
        chk("jump s0", 32'(sample_out), 500);
        chk("jump busy0", 32'(busy), 1);
        @(negedge clk);
        chk("jump s1", 32'(sample_out), 0);
        chk("jump done1", 32'(pulse_done), 1);
        chk("jump ready1", 32'(cmd_ready), 1);
        send(mk_cmd(7, 0, 0));
        chk("direct s0", 32'(sample_out), 7);
        chk("direct busy0", 32'(busy), 1);
        @(negedge clk);
        chk("direct s1", 32'(sample_out), 0);
        chk("direct done1", 32'(pulse_done), 1);
        @(negedge clk);

        // Back-to-back through the pending slot
        bs = '{50, 100, 100, 100, 50, 0, 30, 30, 0};
        bb = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
        bd = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
        br = '{1, 0, 0, 0, 0, 0, 1, 1, 1};
        cmd_data  = mk_cmd(100, 2, 50);
        cmd_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("b2b sample[%0d]", i), 32'(sample_out), 32'(bs[i]));
            chk($sformatf("b2b busy[%0d]", i), 32'(busy), 32'(bb[i]));
            chk($sformatf("b2b done[%0d]", i), 32'(pulse_done), 32'(bd[i]));
            chk($sformatf("b2b ready[%0d]", i), 32'(cmd_ready), 32'(br[i]));
            if (i == 0) cmd_data = mk_cmd(30, 1, 30);
            if (i == 1) cmd_valid = 1'b0;
            @(negedge clk);
        end

        // Saturation: 16 steps of 255, clamp at 4095, hold 1, 16 falls then 0
        k = 0;
        for (int i = 1; i <= 16; i++) begin exp_s[k] = 255 * i; k++; end
        exp_s[k] = 4095; k++;
        exp_s[k] = 4095; k++;
        for (int i = 1; i <= 16; i++) begin exp_s[k] = 4095 - 255 * i; k++; end
        exp_s[k] = 0; k++;
        send(mk_cmd(4095, 1, 255));
        play("sat", k);

        // Amp 0 still runs its full length
        exp_s[0:3] = '{0, 0, 0, 0};
        send(mk_cmd(0, 2, 10));
        play("amp0", 4);

        // Reset in HOLD with a pending command
        cmd_data  = mk_cmd(100, 20, 50);
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("rstmid s0", 32'(sample_out), 50);
        cmd_data = mk_cmd(200, 0, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rstmid hold", 32'(sample_out), 100);
        chk("rstmid pend ready", 32'(cmd_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid sample", 32'(sample_out), 0);
        chk("rstmid busy", 32'(busy), 0);
        chk("rstmid ready", 32'(cmd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid ready after", 32'(cmd_ready), 1);
        max_s    = 0;
        any_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (int'(sample_out) > max_s) max_s = int'(sample_out);
            if (pulse_done || busy) any_done = 1;
            @(negedge clk);
        end
        chk("rstmid no replay sample", 32'(max_s), 0);
        chk("rstmid no replay activity", 32'(any_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/pulse_envelope_gen.md
# pulse_envelope_gen

Turns pulse commands issued by `pulse_scheduler` into a per-cycle DAC amplitude stream, one sample per `clk` cycle. Each pulse is a trapezoid: a linear rise, a flat hold, then a linear fall. The block sits directly downstream of the scheduler in the `ps_clk` domain. It holds one command in a pending register so consecutive pulses run back-to-back with no idle gap beyond a single zero sample.

## Interface
Parameters:
- `AMP_WIDTH`, default 12: amplitude and DAC sample width, unsigned offset-free.
- `LEN_WIDTH`, default 12: hold-length field width, in samples.
- `STEP_WIDTH`, default 8: ramp-step field width. `AMP_WIDTH + LEN_WIDTH + STEP_WIDTH` must equal 32.

Ports:
- `clk`  in  1  pulse clock (`ps_clk` at top level). One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_data`  in  32  pulse command. Fields: `[31:20]` amp, `[19:8]` len, `[7:0]` step.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `sample_out`  out  AMP_WIDTH  registered DAC sample.
- `busy`  out  1  high while the engine state is not IDLE.
- `pulse_done`  out  1  one-cycle strobe; the pulse just finished.

## Operation
- The engine has four states: IDLE, RISE, HOLD, FALL. It keeps an active register (amp, len, step), accumulator `acc` (drives `sample_out`), hold counter `hcnt`, and a one-entry pending register `pend_v`/`pend`.
- `cmd_ready = !pend_v && !rst`. This is combinational from registered state, with no dependence on `cmd_valid`.
- **Launch** happens only at an edge where the state is IDLE.
  - If `pend_v` is set, the pending command launches, and an accept in the same cycle is stored in `pend`.
  - Otherwise, an accepted command launches directly and bypasses `pend`.
  - Outside a launch, an accepted command is written to `pend` and `pend_v` is set.
- **Launch actions:** `acc <= min(step, amp)`; treat step 0 as "jump" (`acc <= amp`).
  - If the first sample already equals amp, the next state is HOLD with `hcnt <= len`, or FALL if len is 0.
  - Otherwise the next state is RISE.
- **RISE:** `acc <= min(acc+step, amp)`. The sum is computed at AMP_WIDTH+1 bits, with no wrap. When the new value equals amp, go to HOLD (`hcnt <= len`), or to FALL if len is 0.
- **HOLD:** `acc` holds amp and `hcnt` decrements. The state is exited so that exactly len samples equal to amp appear after the last rise sample, then go to FALL.
- **FALL:** `acc <= (acc > step && step != 0) ? acc-step : 0`. When the new value is 0, the next state is IDLE and `pulse_done <= 1`. Otherwise remain in FALL.
- Sample counts per pulse:
  - rise = `max(1, ceil(amp/step))`, or 1 if step is 0; the last rise sample equals amp.
  - hold = len.
  - fall = `max(1, ceil(amp/step))`, or 1 if step is 0; the last fall sample is 0 and is shown in IDLE.
- An amp-0 command still runs fully: its samples are 0 for rise, len hold samples, then fall. It produces a `pulse_done`.

## Timing
- Reset values: state IDLE, `acc`/`sample_out` = 0, `hcnt` = 0, `pend_v` = 0, `pulse_done` = 0, `busy` = 0, `cmd_ready` = 0 while `rst` is high. `cmd_ready` = 1 in the first cycle after reset.
- Reset mid-pulse abandons both the active and pending commands. `sample_out` reads 0 in the cycle after the reset edge, and no `pulse_done` is issued.
- Latency: the first rise sample appears on `sample_out` in the cycle after the accepting edge when the engine is IDLE.
- Back-to-back pulses: between pulses there is exactly one 0 sample, the IDLE cycle carrying `pulse_done`. The next pulse's first sample follows immediately.
- Accepting while busy with `pend_v` = 0 fills `pend`, and `cmd_ready` drops the next cycle. When `pend` launches, `cmd_ready` returns high in the cycle after that launch edge.
- Accepting in the IDLE cycle that carries `pulse_done` with `pend_v` = 0 launches directly.
- `cmd_data` is sampled only on an accepting edge. Changes without `cmd_valid` are ignored.

## Test plan
- **Basic pulse:** after reset, send amp=100, len=3, step=40.
  - Required: `sample_out` = 40, 80, 100, 100, 100, 100, 60, 20, 0.
  - `pulse_done` is high in the 0 cycle, and `busy` is high for exactly the 8 preceding cycles.
- **Step 0 / len 0:** send amp=500, len=0, step=0.
  - Required: `sample_out` = 500, 0, with `pulse_done` on the 0 sample.
- **Back-to-back:** hold `cmd_valid` high with A (100/2/50) then B (30/1/30).
  - Required: 50, 100, 100, 100, 50, 0, 30, 30, 0.
  - `cmd_ready` is low from the cycle after B is accepted until the cycle after B launches.
- **Saturation:** send amp=4095, len=1, step=255.
  - Required: no wrap; the last rise sample is 4095, followed by 4095.
  - The fall sequence is 3840, 3585, …, 15, 0: 17 samples.
- **Amp 0:** send amp=0, len=2, step=10.
  - Required: samples 0, 0, 0, 0, with `pulse_done` on the 4th.
- **Reset mid-pulse:** assert `rst` for 1 cycle during HOLD, with a command pending.
  - Required: the next cycle shows `sample_out` 0, `busy` 0, `cmd_ready` 0.
  - The following cycle shows `cmd_ready` 1.
  - The pending command never plays.
